// File: rtl/dram_device_responder.sv
// Cycle-level DRAM device model answering a controller's command bus.
// Decodes commands, tracks banks/timing, stores data, flags violations.
//
// Ports:
//   u_clk, u_rst_n      clock, async active-low reset
//   dram_clk_en         command enable (low = NOP)
//   dram_cs_n/ras_n/cas_n/we_n  command strobes
//   dram_addr           row (ACT) or column (RD/WR)
//   dram_bank_id        bank select
//   dram_wr_data        write data, same cycle as WRITE
//   dram_rd_data/valid  read return, CAS_LATENCY edges after READ
//   open_banks          bit per bank with an open row
//   refresh_count       accepted REFRESH commands (wraps)
//   err_valid/err_code  one-cycle error report
//   err_sticky          any error since reset
module dram_device_responder #(
    parameter int NUMBER_OF_COLUMNS = 8,
    parameter int NUMBER_OF_ROWS    = 128,
    parameter int NUMBER_OF_BANKS   = 8,
    parameter int DRAM_DATA_WIDTH   = 8,
    parameter int CAS_LATENCY       = 2,
    parameter int T_RCD             = 1,
    parameter int T_RP              = 1,
    parameter int REFRESH_TIMEOUT   = 1250,
    localparam int COLUMN_WIDTH     = $clog2(NUMBER_OF_COLUMNS),
    localparam int ROW_WIDTH        = $clog2(NUMBER_OF_ROWS),
    localparam int BANK_ID_WIDTH    = $clog2(NUMBER_OF_BANKS),
    localparam int DRAM_ADDR_WIDTH  =
        (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
    input  logic                       u_clk,
    input  logic                       u_rst_n,
    input  logic                       dram_clk_en,
    input  logic                       dram_cs_n,
    input  logic                       dram_ras_n,
    input  logic                       dram_cas_n,
    input  logic                       dram_we_n,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
    output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
    output logic                       dram_rd_valid,
    output logic [NUMBER_OF_BANKS-1:0] open_banks,
    output logic [15:0]                refresh_count,
    output logic                       err_valid,
    output logic [2:0]                 err_code,
    output logic                       err_sticky
);

    localparam int TMAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TCW   = $clog2(((TMAX < 1) ? 1 : TMAX) + 1);
    localparam int TOW   = $clog2(REFRESH_TIMEOUT + 1);
    localparam int MAW   = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
    localparam int WORDS = NUMBER_OF_BANKS * NUMBER_OF_ROWS
                           * NUMBER_OF_COLUMNS;
    // The edge that issues ACT/PRE already counts as the first of the
    // required cycles, so a counter of N-1 lets the command N edges
    // later through.
    localparam int RCD_L = (T_RCD > 0) ? T_RCD - 1 : 0;
    localparam int RP_L  = (T_RP > 0) ? T_RP - 1 : 0;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_PRE, CMD_WR, CMD_RD, CMD_REF, CMD_ILL
    } cmd_e;

    cmd_e                       w_cmd;
    logic [2:0]                 w_err;
    logic                       w_open;
    logic                       w_tmet;
    logic                       w_act_ok;
    logic                       w_wr_en;
    logic                       w_rd_en;
    logic                       w_tmo_hit;
    logic                       w_pend_any;
    logic [MAW-1:0]             w_maddr;
    logic [DRAM_DATA_WIDTH-1:0] w_rd_word;

    logic [DRAM_DATA_WIDTH-1:0] r_mem [WORDS];
    logic [NUMBER_OF_BANKS-1:0] r_open;
    logic [ROW_WIDTH-1:0]       r_row  [NUMBER_OF_BANKS];
    logic [TCW-1:0]             r_tcnt [NUMBER_OF_BANKS];
    logic [CAS_LATENCY-1:0]     r_pv;
    logic [DRAM_DATA_WIDTH-1:0] r_pd   [CAS_LATENCY];
    logic [DRAM_DATA_WIDTH-1:0] r_rd_data;
    logic                       r_rd_valid;
    logic [15:0]                r_ref_cnt;
    logic [TOW-1:0]             r_tmo;
    logic                       r_pend;
    logic                       r_err_valid;
    logic [2:0]                 r_err_code;
    logic                       r_sticky;

    always_comb begin
        w_cmd = CMD_NOP;
        if (dram_clk_en && !dram_cs_n) begin
            unique case ({dram_ras_n, dram_cas_n, dram_we_n})
                3'b111:  w_cmd = CMD_NOP;
                3'b011:  w_cmd = CMD_ACT;
                3'b010:  w_cmd = CMD_PRE;
                3'b100:  w_cmd = CMD_WR;
                3'b101:  w_cmd = CMD_RD;
                3'b001:  w_cmd = CMD_REF;
                default: w_cmd = CMD_ILL;
            endcase
        end
    end

    assign w_open = r_open[dram_bank_id];
    assign w_tmet = (r_tcnt[dram_bank_id] == '0);

    always_comb begin
        w_err = 3'd0;
        unique case (w_cmd)
            CMD_ILL: w_err = 3'd1;
            CMD_ACT: begin
                if (w_open)       w_err = 3'd2;
                else if (!w_tmet) w_err = 3'd5;
            end
            CMD_WR, CMD_RD: begin
                if (!w_open)      w_err = 3'd3;
                else if (!w_tmet) w_err = 3'd4;
            end
            CMD_REF: begin
                if (|r_open)      w_err = 3'd6;
            end
            default: w_err = 3'd0;
        endcase
    end

    assign w_act_ok = (w_cmd == CMD_ACT) && (w_err == 3'd0);
    assign w_wr_en  = (w_cmd == CMD_WR) && (w_err == 3'd0);
    assign w_rd_en  = (w_cmd == CMD_RD) && (w_err == 3'd0);

    assign w_maddr = {dram_bank_id, r_row[dram_bank_id],
                      dram_addr[COLUMN_WIDTH-1:0]};
    assign w_rd_word = r_mem[w_maddr];

    // A REFRESH on the very edge the timeout would fire pre-empts it.
    assign w_tmo_hit = (w_cmd != CMD_REF)
                    && (r_tmo == TOW'(REFRESH_TIMEOUT - 1));
    assign w_pend_any = r_pend | w_tmo_hit;

    // Storage is deliberately unreset so contents survive u_rst_n.
    always_ff @(posedge u_clk) begin
        if (w_wr_en) begin
            r_mem[w_maddr] <= dram_wr_data;
        end
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            r_open <= '0;
            for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
                r_row[i]  <= '0;
                r_tcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
                if (r_tcnt[i] != '0) begin
                    r_tcnt[i] <= r_tcnt[i] - TCW'(1);
                end
                if (BANK_ID_WIDTH'(i) == dram_bank_id) begin
                    if (w_act_ok) begin
                        r_open[i] <= 1'b1;
                        r_row[i]  <= dram_addr[ROW_WIDTH-1:0];
                        r_tcnt[i] <= TCW'(RCD_L);
                    end
                    if (w_cmd == CMD_PRE) begin
                        r_open[i] <= 1'b0;
                        r_tcnt[i] <= TCW'(RP_L);
                    end
                end
            end
            if (w_cmd == CMD_REF) begin
                r_open <= '0;
            end
        end
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            r_pv       <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            for (int i = 0; i < CAS_LATENCY; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_en;
            r_pd[0] <= w_rd_word;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
            r_rd_valid <= r_pv[CAS_LATENCY-1];
            if (r_pv[CAS_LATENCY-1]) begin
                r_rd_data <= r_pd[CAS_LATENCY-1];
            end
        end
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            r_ref_cnt   <= '0;
            r_tmo       <= '0;
            r_pend      <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
            r_sticky    <= 1'b0;
        end else begin
            if (w_cmd == CMD_REF) begin
                r_ref_cnt <= r_ref_cnt + 16'd1;
            end
            if ((w_cmd == CMD_REF) || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TOW'(1);
            end
            // Command errors win; a timeout waits for a clean cycle.
            if (w_err != 3'd0) begin
                r_err_valid <= 1'b1;
                r_err_code  <= w_err;
                r_pend      <= w_pend_any;
            end else if (w_pend_any) begin
                r_err_valid <= 1'b1;
                r_err_code  <= 3'd7;
                r_pend      <= 1'b0;
            end else begin
                r_err_valid <= 1'b0;
            end
            r_sticky <= r_sticky | (w_err != 3'd0) | w_pend_any;
        end
    end

    assign dram_rd_data  = r_rd_data;
    assign dram_rd_valid = r_rd_valid;
    assign open_banks    = r_open;
    assign refresh_count = r_ref_cnt;
    assign err_valid     = r_err_valid;
    assign err_code      = r_err_code;
    assign err_sticky    = r_sticky;

endmodule

// File: tb/tb_dram_device_responder.sv
// Bench for dram_device_responder: directed command sequences checked
// against a behavioural model every cycle, plus literal spot checks.
module tb_dram_device_responder;

    localparam int CL   = 2;
    localparam int TRCD = 3;
    localparam int TRP  = 2;
    localparam int TMO  = 1250;

    logic        u_clk = 1'b0;
    logic        u_rst_n = 1'b0;
    logic        dram_clk_en = 1'b0;
    logic        dram_cs_n = 1'b1;
    logic        dram_ras_n = 1'b1;
    logic        dram_cas_n = 1'b1;
    logic        dram_we_n = 1'b1;
    logic [6:0]  dram_addr = '0;
    logic [2:0]  dram_bank_id = '0;
    logic [7:0]  dram_wr_data = '0;
    logic [7:0]  dram_rd_data;
    logic        dram_rd_valid;
    logic [7:0]  open_banks;
    logic [15:0] refresh_count;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        err_sticky;

    dram_device_responder #(
        .CAS_LATENCY     (CL),
        .T_RCD           (TRCD),
        .T_RP            (TRP),
        .REFRESH_TIMEOUT (TMO)
    ) dut (
        .u_clk         (u_clk),
        .u_rst_n       (u_rst_n),
        .dram_clk_en   (dram_clk_en),
        .dram_cs_n     (dram_cs_n),
        .dram_ras_n    (dram_ras_n),
        .dram_cas_n    (dram_cas_n),
        .dram_we_n     (dram_we_n),
        .dram_addr     (dram_addr),
        .dram_bank_id  (dram_bank_id),
        .dram_wr_data  (dram_wr_data),
        .dram_rd_data  (dram_rd_data),
        .dram_rd_valid (dram_rd_valid),
        .open_banks    (open_banks),
        .refresh_count (refresh_count),
        .err_valid     (err_valid),
        .err_code      (err_code),
        .err_sticky    (err_sticky)
    );

    always #5 u_clk = ~u_clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string n, input logic [15:0] a,
                       input logic [15:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    // Behavioural model: bank state as "last timing event happened at
    // cycle X and needs Y cycles", reads as a queue of (due cycle, data).
    typedef struct {
        int         due;
        logic [7:0] d;
        bit         k;
    } rq_t;

    int         cyc = 0;
    bit         m_open [8];
    int         m_row  [8];
    int         m_lc   [8];
    int         m_ll   [8];
    logic [7:0] mem_m  [int];
    rq_t        rq [$];
    rq_t        rt;
    int         tbase = 0;
    bit         pend = 0;
    int         c, b, key, err;
    bit         hit, met;
    logic [2:0] op;

    logic        e_valid = 0;
    logic [7:0]  e_data = 0;
    bit          e_dk = 1;
    logic [7:0]  e_open = 0;
    logic [15:0] e_ref = 0;
    logic        e_ev = 0;
    logic [2:0]  e_ec = 0;
    logic        e_st = 0;

    always @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            cyc = 0;
            for (int i = 0; i < 8; i++) begin
                m_open[i] = 0;
                m_row[i]  = 0;
                m_lc[i]   = -100;
                m_ll[i]   = 0;
            end
            rq.delete();
            tbase = 0; pend = 0;
            e_valid = 0; e_data = 0; e_dk = 1; e_open = 0;
            e_ref = 0; e_ev = 0; e_ec = 0; e_st = 0;
        end else begin
            c = cyc;
            b = int'(dram_bank_id);
            err = 0;
            e_valid = 0;
            if (rq.size() > 0 && rq[0].due == c) begin
                e_valid = 1;
                e_data = rq[0].d;
                e_dk = rq[0].k;
                void'(rq.pop_front());
            end
            op = (dram_clk_en && !dram_cs_n)
               ? {dram_ras_n, dram_cas_n, dram_we_n} : 3'b111;
            met = (c - m_lc[b]) >= m_ll[b];
            key = b * 1024 + m_row[b] * 8 + int'(dram_addr[2:0]);
            case (op)
                3'b111: ;
                3'b011: begin
                    if (m_open[b]) err = 2;
                    else if (!met) err = 5;
                    else begin
                        m_open[b] = 1;
                        m_row[b] = int'(dram_addr);
                        m_lc[b] = c;
                        m_ll[b] = TRCD;
                    end
                end
                3'b010: begin
                    m_open[b] = 0;
                    m_lc[b] = c;
                    m_ll[b] = TRP;
                end
                3'b100, 3'b101: begin
                    if (!m_open[b]) err = 3;
                    else if (!met) err = 4;
                    else if (op == 3'b100) mem_m[key] = dram_wr_data;
                    else begin
                        rt.due = c + CL;
                        rt.k = mem_m.exists(key);
                        rt.d = rt.k ? mem_m[key] : 8'h00;
                        rq.push_back(rt);
                    end
                end
                3'b001: begin
                    for (int i = 0; i < 8; i++) begin
                        if (m_open[i]) err = 6;
                        m_open[i] = 0;
                    end
                    e_ref = e_ref + 16'd1;
                    tbase = c + 1;
                end
                default: err = 1;
            endcase
            hit = (op != 3'b001) && (c - tbase == TMO - 1);
            if (hit) tbase = c + 1;
            if (err != 0) begin
                e_ev = 1; e_ec = 3'(err); pend = pend | hit;
            end else if (pend | hit) begin
                e_ev = 1; e_ec = 3'd7; pend = 0;
            end else begin
                e_ev = 0;
            end
            e_st = e_st | e_ev;
            for (int i = 0; i < 8; i++) e_open[i] = m_open[i];
            cyc = cyc + 1;
        end
    end

    always @(negedge u_clk) begin
        chk("rd_valid", {15'd0, dram_rd_valid}, {15'd0, e_valid});
        if (e_dk) chk("rd_data", {8'd0, dram_rd_data}, {8'd0, e_data});
        chk("open_banks", {8'd0, open_banks}, {8'd0, e_open});
        chk("refresh_count", refresh_count, e_ref);
        chk("err_valid", {15'd0, err_valid}, {15'd0, e_ev});
        chk("err_code", {13'd0, err_code}, {13'd0, e_ec});
        chk("err_sticky", {15'd0, err_sticky}, {15'd0, e_st});
    end

    task automatic cmd(input logic [2:0] rcw, input int bk, input int a,
                       input int d);
        dram_clk_en = 1'b1;
        dram_cs_n = 1'b0;
        {dram_ras_n, dram_cas_n, dram_we_n} = rcw;
        dram_bank_id = 3'(bk);
        dram_addr = 7'(a);
        dram_wr_data = 8'(d);
        @(negedge u_clk);
        dram_cs_n = 1'b1;
        {dram_ras_n, dram_cas_n, dram_we_n} = 3'b111;
    endtask

    task automatic nop(input int n);
        repeat (n) @(negedge u_clk);
    endtask

    task automatic act(input int bk, input int r);
        cmd(3'b011, bk, r, 0);
    endtask
    task automatic pre(input int bk);
        cmd(3'b010, bk, 0, 0);
    endtask
    task automatic wr(input int bk, input int col, input int d);
        cmd(3'b100, bk, col, d);
    endtask
    task automatic rd(input int bk, input int col);
        cmd(3'b101, bk, col, 0);
    endtask

    int n7, nv, got, k, fst, lst;
    logic [7:0] gd [8];

    task automatic cap();
        if (dram_rd_valid) begin
            if (got < 8) gd[got] = dram_rd_data;
            if (got == 0) fst = k;
            lst = k;
            got++;
        end
        k++;
    endtask

    initial begin
        @(negedge u_clk);
        nop(2);
        chk("rst_rd_valid", {15'd0, dram_rd_valid}, 16'd0);
        chk("rst_open", {8'd0, open_banks}, 16'd0);
        chk("rst_refcnt", refresh_count, 16'd0);
        chk("rst_err_code", {13'd0, err_code}, 16'd0);
        chk("rst_sticky", {15'd0, err_sticky}, 16'd0);
        u_rst_n = 1'b1;
        nop(1);

        act(3, 17); nop(2);
        wr(3, 5, 8'hA5);
        chk("wr_noerr", {15'd0, err_valid}, 16'd0);
        rd(3, 5);
        chk("rd_noerr", {15'd0, err_valid}, 16'd0);
        nop(1);
        chk("rd_lat1", {15'd0, dram_rd_valid}, 16'd0);
        nop(1);
        chk("rd_lat2", {15'd0, dram_rd_valid}, 16'd1);
        chk("rd_a5", {8'd0, dram_rd_data}, 16'h00A5);

        act(1, 4); nop(2); wr(1, 0, 8'h11); pre(1); nop(1);
        act(1, 9); nop(2); wr(1, 0, 8'h22); pre(1); nop(1);
        act(1, 4);
        act(1, 9);
        chk("act_open_code", {13'd0, err_code}, 16'd2);
        nop(1);
        rd(1, 0); nop(2);
        chk("row_kept", {8'd0, dram_rd_data}, 16'h0011);
        rd(2, 0);
        chk("closed_code", {13'd0, err_code}, 16'd3);
        nop(2);
        chk("closed_novalid", {15'd0, dram_rd_valid}, 16'd0);
        pre(1);
        act(1, 4);
        chk("trp_code", {13'd0, err_code}, 16'd5);

        act(0, 1); nop(2); wr(0, 2, 8'h5A); pre(0); nop(1);
        act(0, 1);
        rd(0, 2);
        chk("trcd_code", {13'd0, err_code}, 16'd4);
        nop(1);
        rd(0, 2);
        chk("trcd_ok", {15'd0, err_valid}, 16'd0);
        chk("trcd_novalid", {15'd0, dram_rd_valid}, 16'd0);
        nop(2);
        chk("trcd_data", {7'd0, dram_rd_valid, dram_rd_data}, 16'h015A);

        act(2, 0);
        cmd(3'b001, 0, 0, 0);
        chk("ref_code", {13'd0, err_code}, 16'd6);
        chk("ref_open", {8'd0, open_banks}, 16'd0);
        chk("ref_cnt", refresh_count, 16'd1);
        n7 = 0;
        repeat (1260) begin
            nop(1);
            if (err_valid && err_code == 3'd7) n7++;
        end
        chk("timeout_once", 16'(n7), 16'd1);

        cmd(3'b000, 0, 0, 0);
        chk("ill_code", {13'd0, err_code}, 16'd1);
        chk("ill_sticky", {15'd0, err_sticky}, 16'd1);

        act(5, 2); nop(2); wr(5, 1, 8'h77);
        rd(5, 1);
        #2 u_rst_n = 1'b0;
        nop(2);
        u_rst_n = 1'b1;
        nv = 0;
        repeat (4) begin
            nop(1);
            if (dram_rd_valid) nv++;
        end
        chk("rst_flush", 16'(nv), 16'd0);
        chk("rst_sticky_clr", {15'd0, err_sticky}, 16'd0);
        act(5, 2); nop(2); rd(5, 1); nop(2);
        chk("retained", {7'd0, dram_rd_valid, dram_rd_data}, 16'h0177);

        act(4, 7); nop(2);
        for (int i = 0; i < 8; i++) wr(4, i, 8'h40 + i);
        got = 0; k = 0; fst = 0; lst = 0;
        for (int i = 0; i < 8; i++) begin
            rd(4, i);
            cap();
        end
        repeat (4) begin
            nop(1);
            cap();
        end
        chk("b2b_count", 16'(got), 16'd8);
        chk("b2b_span", 16'(lst - fst), 16'd7);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_data", {8'd0, gd[i]}, 16'h40 + 16'(i));
        end

        nop(2);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
